// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-side program counter controller for the single-issue CPU. Owns the PC,
// issues instruction fetches over a req/ack memory handshake, hands fetched
// words to decode over valid/ready, and applies branch/jump redirects and halt.
//
// Optional feature macro: PC_SEQ_TRAP_EN
//   When defined, the `trap` input and `epc` output exist. A trap behaves like
//   a redirect to TRAP_VECTOR, wins over a same-cycle redirect, and records the
//   faulting PC in `epc`.
//
// Parameters
//   RESET_VECTOR  PC loaded on reset
//   TRAP_VECTOR   PC loaded on trap (PC_SEQ_TRAP_EN only)
//
// Ports
//   clock            in   single clock, rising edge
//   reset            in   asynchronous active-low reset
//   imem_req         out  fetch request, held until imem_ack
//   imem_addr        out  fetch address, stable while imem_req=1
//   imem_ack         in   one-cycle completion pulse
//   imem_rdata       in   instruction word, valid with imem_ack
//   instr_valid      out  instruction available to decode
//   instr            out  instruction word
//   instr_pc         out  address of instr
//   instr_ready      in   decode accepts on instr_valid & instr_ready
//   redirect_valid   in   branch/jump taken pulse
//   redirect_target  in   new PC (bits [1:0] ignored)
//   halt             in   sampled at the issue handshake
//   pc               out  current fetch PC
//   halted           out  high while halted
//   trap             in   exception pulse        (PC_SEQ_TRAP_EN only)
//   epc              out  faulting PC            (PC_SEQ_TRAP_EN only)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
`endif
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        halted
`ifdef PC_SEQ_TRAP_EN
    ,
    input  logic        trap,
    output logic [31:0] epc
`endif
);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    state_e      state_q,    state_d;
    logic        boot_wait_q, boot_wait_d;
    logic [31:0] pc_q,       pc_d;
    logic        req_q,      req_d;
    logic [31:0] addr_q,     addr_d;
    logic        valid_q,    valid_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        halted_q,   halted_d;

    // Control-flow change requested this cycle and where it goes.
    logic        jump_s;
    logic [31:0] jump_pc_s;
    // PC to fetch from next: the jump target if one is pending, else the PC.
    logic [31:0] next_pc_s;

    // Word-align a redirect target.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

`ifdef PC_SEQ_TRAP_EN
    logic [31:0] epc_q, epc_d;

    // Trap outranks redirect; both steer the fetch stream the same way.
    always_comb begin
        jump_s    = trap | redirect_valid;
        jump_pc_s = 32'h0000_0000;
        if (trap) begin
            jump_pc_s = TRAP_VECTOR;
        end else begin
            jump_pc_s = align_word(redirect_target);
        end
    end

    // Faulting PC: the instruction on offer to decode, otherwise the fetch PC.
    always_comb begin
        epc_d = epc_q;
        if (trap && (state_q != ST_BOOT)) begin
            if (state_q == ST_ISSUE) begin
                epc_d = instr_pc_q;
            end else begin
                epc_d = pc_q;
            end
        end else begin
            epc_d = epc_q;
        end
    end

    // Exception PC register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            epc_q <= 32'h0000_0000;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc = epc_q;
`else
    // Only redirects steer the fetch stream in this build.
    always_comb begin
        jump_s    = redirect_valid;
        jump_pc_s = align_word(redirect_target);
    end
`endif

    assign next_pc_s = jump_s ? jump_pc_s : pc_q;

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        state_d     = state_q;
        boot_wait_d = boot_wait_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        halted_d    = halted_q;

        case (state_q)
            // The first edge after reset release is absorbed so that the
            // first request lands two cycles after release; jumps are ignored.
            ST_BOOT: begin
                if (boot_wait_q) begin
                    boot_wait_d = 1'b0;
                    state_d     = ST_FETCH;
                    req_d       = 1'b1;
                    addr_d      = pc_q;
                end else begin
                    boot_wait_d = 1'b1;
                end
            end

            ST_FETCH: begin
                if (jump_s) begin
                    pc_d = jump_pc_s;
                    if (imem_ack) begin
                        // Returning word is stale; re-request at the target
                        // right away, so imem_req stays high.
                        addr_d = jump_pc_s;
                    end else begin
                        // Outstanding request must complete before a new one.
                        state_d = ST_FLUSH;
                    end
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    req_d      = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_FLUSH: begin
                // Latest jump target wins while waiting out the old request.
                pc_d = next_pc_s;
                if (imem_ack) begin
                    state_d = ST_FETCH;
                    addr_d  = next_pc_s;
                end else begin
                    state_d = ST_FLUSH;
                end
            end

            ST_ISSUE: begin
                if (jump_s) begin
                    // A jump beats a same-cycle accept; decode drops the word.
                    pc_d    = jump_pc_s;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    addr_d  = jump_pc_s;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    if (halt) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end

            ST_HALTED: begin
                if (jump_s) begin
                    pc_d     = jump_pc_s;
                    halted_d = 1'b0;
                    state_d  = ST_FETCH;
                    req_d    = 1'b1;
                    addr_d   = jump_pc_s;
                end else begin
                    state_d = ST_HALTED;
                end
            end

            default: begin
                state_d     = ST_BOOT;
                boot_wait_d = 1'b0;
                req_d       = 1'b0;
                valid_d     = 1'b0;
                halted_d    = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BOOT;
            boot_wait_q <= 1'b0;
            pc_q        <= RESET_VECTOR;
            req_q       <= 1'b0;
            addr_q      <= RESET_VECTOR;
            valid_q     <= 1'b0;
            instr_q     <= 32'h0000_0000;
            instr_pc_q  <= 32'h0000_0000;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_wait_q <= boot_wait_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            halted_q    <= halted_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller for the program counter in the single-issue CPU. It owns the PC register and sequences instruction fetch over a req/ack memory handshake. It presents fetched instructions to decode with a valid/ready handshake and applies branch/jump redirects and halt. It replaces free-running PC increment with a state machine that stalls on memory and decode back-pressure.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded on reset.
- `TRAP_VECTOR`, default 32'h0000_0080: PC loaded on trap (only with `PC_SEQ_TRAP_EN`).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) resets immediately; deassertion is synchronised externally.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  instruction available to decode.
- `instr`  out  32  instruction word.
- `instr_pc`  out  32  address of `instr`.
- `instr_ready`  in  1  decode accepts when `instr_valid` & `instr_ready`.
- `redirect_valid`  in  1  single-cycle branch/jump taken pulse.
- `redirect_target`  in  32  new PC; bits [1:0] are forced to 0.
- `halt`  in  1  sampled only at the issue handshake.
- `pc`  out  32  current fetch PC.
- `halted`  out  1  high in HALTED.
- `trap`  in  1  (`PC_SEQ_TRAP_EN` only) exception pulse.
- `epc`  out  32  (`PC_SEQ_TRAP_EN` only) faulting PC.

## Operation
- States: BOOT, FETCH, FLUSH, ISSUE, HALTED. All outputs are registered.
- Reset values:
  - State: BOOT.
  - Zero: `pc`, `imem_addr`, `instr`, `instr_pc`, `epc`.
  - RESET_VECTOR: `pc` and `imem_addr` (overrides the zero above).
  - Low: `imem_req`, `instr_valid`, `halted`.
- BOOT: one cycle, then FETCH with `imem_req`=1 and `imem_addr`=`pc`.
- FETCH on `imem_ack`:
  - `instr` <= `imem_rdata`; `instr_pc` <= `pc`.
  - `pc` <= `pc`+4, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - `imem_req` <= 0; `instr_valid` <= 1; go to ISSUE.
- ISSUE: `instr_valid` holds with stable data until `instr_ready`.
  - On handshake with `halt`=1: go to HALTED.
  - On handshake with `halt`=0: go to FETCH and re-raise `imem_req` with `imem_addr`=`pc`.
- HALTED: no requests. Leaves only on redirect, trap or reset.
- Redirect (ignored in BOOT). It sets `pc` <= {`redirect_target`[31:2],2'b00}, then:
  - In ISSUE: `instr_valid` <= 0; go to FETCH. Redirect beats a same-cycle `instr_ready`; decode must discard that instruction.
  - In FETCH without `imem_ack`: the outstanding request must complete. Go to FLUSH with `imem_req` and `imem_addr` held. On `imem_ack`, discard the data and go to FETCH with the new `pc`.
  - In FETCH with a same-cycle `imem_ack`: discard the data (`instr_valid` stays 0); go to FETCH with the new `pc`.
  - In FLUSH: latest target wins; stay in FLUSH.
  - In HALTED: `halted` <= 0; go to FETCH.

## Timing
- First `imem_req` appears 2 cycles after reset deasserts.
- `imem_ack` in cycle N gives `instr_valid` in N+1.
- Handshake in cycle M gives `imem_req` in M+1.
- Best-case throughput is one instruction per 2 cycles plus memory latency.
- Redirect in cycle N: new `imem_addr` in N+1, unless a FLUSH is pending.
- `imem_req` never drops without `imem_ack`, including across redirects.
- `reset` assertion mid-request drops `imem_req` immediately; the memory must tolerate abandoned requests.

## Configuration
- `PC_SEQ_TRAP_EN` defined: `trap` and `epc` ports exist. Trap beats redirect in the same cycle.
  - `epc` <= `instr_pc` if in ISSUE, else `pc`.
  - Then `pc` <= TRAP_VECTOR and `halted` <= 0.
  - FLUSH handling is the same as for redirect.
- `PC_SEQ_TRAP_EN` undefined: no `trap` or `epc` ports, no trap logic; behaviour is otherwise identical.

## Test plan
- Reset release, `imem_ack` 1 cycle after each req, `instr_ready`=1 → `imem_addr` sequence 0,4,8,12; first req 2 cycles after release.
- `instr_ready` held low 5 cycles → `instr_valid`, `instr`, `instr_pc` stable, no new `imem_req`, `pc`=`instr_pc`+4.
- `redirect_valid` with target 32'h0000_0103 during FETCH, ack 3 cycles later → old data dropped, next `imem_addr`=32'h0000_0100, `instr_valid` never high for old word.
- Halt at handshake, then redirect to 32'h40 → `halted`=1, no requests until redirect, then `imem_addr`=32'h40.
- PC at 32'hFFFF_FFFC, ack → next `imem_addr`=0.
- With `PC_SEQ_TRAP_EN`: trap and redirect in the same ISSUE cycle, `instr_pc`=32'h20 → `epc`=32'h20, next `imem_addr`=32'h80.
